// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: load funct3 encodings, writeback FSM states and
// the context captured while a load waits for its memory acknowledge.
package rv32i_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned LSB_W   = 2;

    typedef enum logic [F3_W-1:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [0:0] {
        WB_IDLE     = 1'b0,
        WB_WAIT_ACK = 1'b1
    } wb_state_e;

    // Fields of a load held across the WAIT_ACK window.
    typedef struct packed {
        logic              wr;
        logic [REG_AW-1:0] rd_addr;
        logic [F3_W-1:0]   funct3;
        logic [LSB_W-1:0]  lsb;
    } load_ctx_t;

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load formatter: selects byte/half/word from a memory word by
// byte offset and sign- or zero-extends it according to funct3.
module rv32i_load_align
    import rv32i_pkg::*;
(
    input  logic [F3_W-1:0]  funct3_i,
    input  logic [LSB_W-1:0] addr_lsb_i,
    input  logic [XLEN-1:0]  word_i,
    output logic [XLEN-1:0]  data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[7:0];
        case (addr_lsb_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        // Halves use only the upper offset bit; misaligned halves are not trapped here.
        half_v = addr_lsb_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   data_o = {{16{half_v[15]}}, half_v};
            F3_LW:   data_o = word_i;
            F3_LBU:  data_o = {24'd0, byte_v};
            F3_LHU:  data_o = {16'd0, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/rv32i_writeback.sv
// rv32i stage 5: registers ALU or formatted load results into the regfile
// write port, stalling upstream while a slow load waits for its acknowledge.
module rv32i_writeback
    import rv32i_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 8
)
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce,
    input  logic              i_flush,
    input  logic              i_wr_rd,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic [XLEN-1:0]   i_alu_result,
    input  logic              i_load,
    input  logic [F3_W-1:0]   i_funct3,
    input  logic [LSB_W-1:0]  i_addr_lsb,
    input  logic              i_ack,
    input  logic [XLEN-1:0]   i_load_data,
    output logic              o_stall,
    output logic              o_wr,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic [XLEN-1:0]   o_rd,
    output logic              o_bus_err
);

    wb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    load_ctx_t         ctx_q, ctx_d;
    logic              wr_q, wr_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic              bus_err_q, bus_err_d;
    logic              stall_c;

    logic [F3_W-1:0]   fmt_funct3;
    logic [LSB_W-1:0]  fmt_lsb;
    logic [XLEN-1:0]   fmt_data;

    // A waiting load formats with its captured fields; otherwise use live inputs.
    assign fmt_funct3 = (state_q == WB_WAIT_ACK) ? ctx_q.funct3 : i_funct3;
    assign fmt_lsb    = (state_q == WB_WAIT_ACK) ? ctx_q.lsb    : i_addr_lsb;

    rv32i_load_align u_load_align (
        .funct3_i   (fmt_funct3),
        .addr_lsb_i (fmt_lsb),
        .word_i     (i_load_data),
        .data_o     (fmt_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= WB_IDLE;
            cnt_q     <= '0;
            ctx_q     <= '0;
            wr_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctx_q     <= ctx_d;
            wr_q      <= wr_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state and write-port logic; flush overrides everything in both states.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctx_d     = ctx_q;
        wr_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_d      = rd_q;
        bus_err_d = 1'b0;
        stall_c   = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (i_ce && !i_flush) begin
                    if (!i_load) begin
                        wr_d      = i_wr_rd && (i_rd_addr != '0);
                        rd_addr_d = i_rd_addr;
                        rd_d      = i_alu_result;
                    end else if (i_ack) begin
                        wr_d      = i_wr_rd && (i_rd_addr != '0);
                        rd_addr_d = i_rd_addr;
                        rd_d      = fmt_data;
                    end else begin
                        ctx_d.wr      = i_wr_rd;
                        ctx_d.rd_addr = i_rd_addr;
                        ctx_d.funct3  = i_funct3;
                        ctx_d.lsb     = i_addr_lsb;
                        cnt_d         = CNT_W'(1);
                        state_d       = WB_WAIT_ACK;
                        stall_c       = 1'b1;
                    end
                end
            end
            WB_WAIT_ACK: begin
                // Held through the ack cycle so no new instruction slips in.
                stall_c = 1'b1;
                if (i_flush) begin
                    state_d = WB_IDLE;
                    cnt_d   = '0;
                end else if (i_ack) begin
                    wr_d      = ctx_q.wr && (ctx_q.rd_addr != '0);
                    rd_addr_d = ctx_q.rd_addr;
                    rd_d      = fmt_data;
                    state_d   = WB_IDLE;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_W'(LOAD_TIMEOUT)) begin
                    bus_err_d = 1'b1;
                    state_d   = WB_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = WB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall is forced low while reset is held, even if a load is presented.
    assign o_stall   = stall_c & i_rst_n;
    assign o_wr      = wr_q;
    assign o_rd_addr = rd_addr_q;
    assign o_rd      = rd_q;
    assign o_bus_err = bus_err_q;

endmodule

// File: tb/tb_rv32i_writeback.sv
// Self-checking bench for rv32i_writeback: directed cases followed by random
// traffic compared against a cycle-level reference model.
module tb_rv32i_writeback;

    localparam int unsigned T_OUT = 4;

    logic        clk;
    logic        rst_n;
    logic        ce, flush, wr_rd, load, ack;
    logic [4:0]  rd_addr;
    logic [31:0] alu, ldata;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic        stall, wr, bus_err;
    logic [4:0]  o_addr;
    logic [31:0] o_data;

    int n_checks = 0;
    int n_errors = 0;

    rv32i_writeback #(.LOAD_TIMEOUT(T_OUT), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ce         (ce),
        .i_flush      (flush),
        .i_wr_rd      (wr_rd),
        .i_rd_addr    (rd_addr),
        .i_alu_result (alu),
        .i_load       (load),
        .i_funct3     (f3),
        .i_addr_lsb   (lsb),
        .i_ack        (ack),
        .i_load_data  (ldata),
        .o_stall      (stall),
        .o_wr         (wr),
        .o_rd_addr    (o_addr),
        .o_rd         (o_data),
        .o_bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference load formatting computed with shifts and masks.
    function automatic logic [31:0] ref_fmt(input int unsigned fn, input int unsigned off,
                                            input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (fn)
            0:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            1:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4:       return b;
            5:       return h;
            default: return w;
        endcase
    endfunction

    task automatic idle_inputs();
        ce = 0; flush = 0; wr_rd = 0; load = 0; ack = 0;
        rd_addr = '0; alu = '0; ldata = '0; f3 = '0; lsb = '0;
    endtask

    // Same-cycle load vectors on word 0x8081_82F3.
    logic [2:0]  sc_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  sc_lsb [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] sc_exp [5] = '{32'hFFFF_FFF3, 32'h0000_0080, 32'hFFFF_8081,
                                32'h0000_82F3, 32'h8081_82F3};

    // Model state: one outstanding load and how long it has waited.
    bit          m_busy;
    int unsigned m_age;
    bit          m_wr;
    logic [4:0]  m_rd;
    int unsigned m_f3, m_lsb;

    initial begin
        int nst, nerr, nwr;
        bit e_stall, e_wr, e_err;
        logic [4:0]  e_addr;
        logic [31:0] e_data;

        idle_inputs();
        rst_n = 0;
        #1;
        check("reset_stall_gated", 32'(stall), 32'd0);
        ce = 1; load = 1; ack = 0;
        #1;
        check("reset_stall_gated_load", 32'(stall), 32'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_wr", 32'(wr), 32'd0);
        check("reset_addr", 32'(o_addr), 32'd0);
        check("reset_rd", o_data, 32'd0);
        check("reset_err", 32'(bus_err), 32'd0);
        rst_n = 1;
        cyc();

        // ALU write
        ce = 1; wr_rd = 1; rd_addr = 5; alu = 32'h1234_5678;
        #1;
        check("alu_stall", 32'(stall), 32'd0);
        cyc();
        check("alu_wr", 32'(wr), 32'd1);
        check("alu_addr", 32'(o_addr), 32'd5);
        check("alu_data", o_data, 32'h1234_5678);
        idle_inputs();
        cyc();
        check("alu_wr_pulse", 32'(wr), 32'd0);

        // Same-cycle loads
        for (int i = 0; i < 5; i++) begin
            ce = 1; load = 1; ack = 1; wr_rd = 1; rd_addr = 5'(i + 1);
            f3 = sc_f3[i]; lsb = sc_lsb[i]; ldata = 32'h8081_82F3;
            #1;
            check($sformatf("sc_stall_%0d", i), 32'(stall), 32'd0);
            cyc();
            check($sformatf("sc_wr_%0d", i), 32'(wr), 32'd1);
            check($sformatf("sc_data_%0d", i), o_data, sc_exp[i]);
        end
        idle_inputs();
        cyc();

        // Delayed ack: issue cycle plus three wait cycles, ack in the last
        nst = 0;
        ce = 1; load = 1; wr_rd = 1; rd_addr = 7; f3 = 3'b010; ldata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            ack = (k == 3);
            #1;
            nst += int'(stall);
            cyc();
            ce = 0;
        end
        ack = 0;
        check("dly_stall_cycles", 32'(nst), 32'd4);
        check("dly_wr", 32'(wr), 32'd1);
        check("dly_addr", 32'(o_addr), 32'd7);
        check("dly_data", o_data, 32'hDEAD_BEEF);
        #1;
        check("dly_stall_drop", 32'(stall), 32'd0);
        idle_inputs();
        cyc();

        // Timeout
        nst = 0; nerr = 0; nwr = 0;
        ce = 1; load = 1; wr_rd = 1; rd_addr = 3; f3 = 3'b010;
        for (int k = 0; k < 10; k++) begin
            #1;
            nst += int'(stall);
            cyc();
            ce = 0;
            nerr += int'(bus_err);
            nwr += int'(wr);
        end
        idle_inputs();
        check("to_stall_cycles", 32'(nst), 32'(T_OUT + 1));
        check("to_err_pulses", 32'(nerr), 32'd1);
        check("to_no_write", 32'(nwr), 32'd0);
        #1;
        check("to_stall_drop", 32'(stall), 32'd0);
        check("to_hold_addr", 32'(o_addr), 32'd7);
        check("to_hold_data", o_data, 32'hDEAD_BEEF);
        cyc();

        // Flush coincident with ack
        ce = 1; load = 1; wr_rd = 1; rd_addr = 9; f3 = 3'b010;
        cyc();
        ce = 0; flush = 1; ack = 1; ldata = 32'h5555_AAAA;
        cyc();
        idle_inputs();
        check("fl_no_write", 32'(wr), 32'd0);
        check("fl_no_err", 32'(bus_err), 32'd0);
        #1;
        check("fl_stall_drop", 32'(stall), 32'd0);
        check("fl_hold_data", o_data, 32'hDEAD_BEEF);
        cyc();

        // Asynchronous reset mid-WAIT_ACK
        ce = 1; load = 1; wr_rd = 1; rd_addr = 10; f3 = 3'b010;
        cyc();
        ce = 0;
        #2;
        rst_n = 0;
        #1;
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_data", o_data, 32'd0);
        check("rst_mid_addr", 32'(o_addr), 32'd0);
        cyc();
        rst_n = 1;
        ack = 1; ldata = 32'h0BAD_F00D;
        nwr = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            nwr += int'(wr);
        end
        check("rst_no_write", 32'(nwr), 32'd0);
        idle_inputs();
        cyc();

        // x0 destination
        ce = 1; wr_rd = 1; rd_addr = 0; alu = 32'hFFFF_FFFF;
        cyc();
        check("x0_no_write", 32'(wr), 32'd0);
        idle_inputs();
        cyc();

        // Random traffic against the model
        m_busy = 0; m_age = 0; m_wr = 0; m_rd = '0; m_f3 = 0; m_lsb = 0;
        for (int n = 0; n < 600; n++) begin
            ce      = ($urandom_range(0, 9) < 7);
            flush   = ($urandom_range(0, 19) == 0);
            wr_rd   = ($urandom_range(0, 9) < 8);
            rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu     = $urandom;
            load    = $urandom_range(0, 1) == 1;
            f3      = 3'($urandom_range(0, 7));
            lsb     = 2'($urandom_range(0, 3));
            ack     = ($urandom_range(0, 9) < 3);
            ldata   = $urandom;

            e_stall = m_busy || (ce && !flush && load && !ack);
            e_wr = 0; e_err = 0; e_addr = '0; e_data = '0;
            if (m_busy) begin
                if (flush) begin
                    m_busy = 0;
                end else if (ack) begin
                    e_wr = m_wr && (m_rd != 0);
                    e_addr = m_rd;
                    e_data = ref_fmt(m_f3, m_lsb, ldata);
                    m_busy = 0;
                end else if (m_age == T_OUT) begin
                    e_err = 1;
                    m_busy = 0;
                end else begin
                    m_age++;
                end
            end else if (ce && !flush) begin
                if (!load || ack) begin
                    e_wr = wr_rd && (rd_addr != 0);
                    e_addr = rd_addr;
                    e_data = load ? ref_fmt(int'(f3), int'(lsb), ldata) : alu;
                end else begin
                    m_busy = 1; m_age = 1;
                    m_wr = wr_rd; m_rd = rd_addr; m_f3 = int'(f3); m_lsb = int'(lsb);
                end
            end

            #1;
            check("rnd_stall", 32'(stall), 32'(e_stall));
            cyc();
            check("rnd_wr", 32'(wr), 32'(e_wr));
            check("rnd_err", 32'(bus_err), 32'(e_err));
            if (e_wr) begin
                check("rnd_addr", 32'(o_addr), 32'(e_addr));
                check("rnd_data", o_data, e_data);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32i_writeback.md
Name: rv32i_writeback

Overview:
- Stage 5 (WRITEBACK) of the rv32i pipeline.
- Consumes the memory-stage result: either an ALU value, or load data from the data memory.
- Formats load data by funct3 and byte offset, waits for a slow memory acknowledge while stalling upstream, and drives a registered write port into the base register file (rd address, rd data, write enable).

Parameters:
- LOAD_TIMEOUT, 255: max cycles spent in WAIT_ACK before a bus error is flagged; must be 1..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > LOAD_TIMEOUT.

Ports:
- i_clk  in  1  clock; all flops rise on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ce  in  1  stage enable; memory stage presents a valid instruction this cycle.
- i_flush  in  1  kill the instruction in this stage; no register write.
- i_wr_rd  in  1  instruction writes rd.
- i_rd_addr  in  5  destination register address.
- i_alu_result  in  32  value to write for non-load instructions.
- i_load  in  1  instruction is a load.
- i_funct3  in  3  load type.
- i_addr_lsb  in  2  byte offset of the load address.
- i_ack  in  1  data memory acknowledge; i_load_data is valid when high.
- i_load_data  in  32  raw 32-bit word read from data memory.
- o_stall  out  1  combinational; upstream must hold the stage inputs.
- o_wr  out  1  registered write enable to the regfile.
- o_rd_addr  out  5  registered destination address.
- o_rd  out  32  registered write data.
- o_bus_err  out  1  registered one-cycle pulse on load timeout.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, counter=0.
  - o_wr=0, o_rd_addr=0, o_rd=0, o_bus_err=0; o_stall=0.
- o_wr and o_bus_err are single-cycle pulses: 0 in every cycle that does not register a write or a timeout.
- o_rd_addr and o_rd hold their last value when o_wr=0.
- o_wr is never asserted with o_rd_addr=0; the write is suppressed, while the address and data registers still update.
- IDLE, i_ce=1, i_flush=0:
  - i_load=0: next edge latches o_wr=i_wr_rd, o_rd_addr=i_rd_addr, o_rd=i_alu_result. Latency 1 cycle.
  - i_load=1, i_ack=1: next edge latches o_rd=fmt(i_load_data), o_wr=i_wr_rd. Latency 1 cycle, no stall.
  - i_load=1, i_ack=0: capture rd_addr, wr_rd, funct3 and addr_lsb internally; go to WAIT_ACK; counter=1; o_stall=1 this cycle.
- WAIT_ACK:
  - o_stall=1 every cycle, including the i_ack cycle, so upstream never advances a new instruction during the ack cycle.
  - i_ack=1: latch o_rd=fmt(i_load_data) using the captured fields; o_wr=captured wr_rd; go to IDLE.
  - i_ack=0 and counter==LOAD_TIMEOUT: o_bus_err=1 for one cycle, o_wr=0, go to IDLE.
  - Otherwise counter+1.
  - Inputs i_ce, i_load etc. are ignored in WAIT_ACK.
- i_flush has priority over everything in both states:
  - o_wr=0 next cycle, state goes to IDLE, counter cleared, no o_bus_err.
  - A simultaneous i_ack is discarded.
- fmt(word), with byte b = word[8*lsb+7 : 8*lsb] and half h = lsb[1] ? word[31:16] : word[15:0] (lsb[0] ignored for halves):
  - 000 LB: sign-extended b.
  - 001 LH: sign-extended h.
  - 010 LW: word.
  - 100 LBU: zero-extended b.
  - 101 LHU: zero-extended h.
  - Any other value: word (treated as LW).
- Reset asserted mid-WAIT_ACK aborts the load immediately; no write occurs after release.

Decomposition:
- Shared package rv32i_pkg holds:
  - funct3 load encodings: LB, LH, LW, LBU, LHU.
  - State encoding: IDLE, WAIT_ACK.
- One sub-module, rv32i_load_align: purely combinational fmt(), inputs funct3, addr_lsb and word, output 32-bit; reusable by a future load-forwarding path.

Test Plan:
- ALU write:
  - Stimulus: i_ce=1, i_load=0, i_wr_rd=1, rd=5, alu=0x1234_5678.
  - Required: next cycle o_wr=1, o_rd_addr=5, o_rd=0x12345678; o_wr=0 the cycle after.
- Same-cycle loads, word 0x8081_82F3 with i_ack=1:
  - LB lsb=0 -> 0xFFFF_FFF3.
  - LBU lsb=3 -> 0x0000_0080.
  - LH lsb=2 -> 0xFFFF_8081.
  - LHU lsb=0 -> 0x0000_82F3.
  - LW -> 0x8081_82F3.
- Delayed ack:
  - Stimulus: LW to rd=7, ack after 3 cycles, data=0xDEAD_BEEF.
  - Required: o_stall=1 for 4 cycles including the ack cycle; then o_wr=1, o_rd_addr=7, o_rd=0xDEADBEEF.
- Timeout:
  - Stimulus: LOAD_TIMEOUT=4, load to rd=3, i_ack never asserted.
  - Required: o_bus_err pulses once, o_wr stays 0, o_stall drops, state returns to IDLE.
- Flush and reset during WAIT_ACK:
  - Flush coincident with i_ack -> no write, o_stall=0 next cycle.
  - i_rst_n=0 during WAIT_ACK -> all outputs 0 immediately (asynchronous), no write after release.
- x0 destination:
  - Stimulus: i_ce=1, i_load=0, i_wr_rd=1, rd=0, alu=0xFFFF_FFFF.
  - Required: o_wr stays 0.
